proba_sequencer: RTL and testbench
==================================

# proba_sequencer

Run sequencer for the line-follower car. Takes the raw track-select push-button, filters it with a synchronizer and a 1 s lockout, and cycles the selected trial (straight line, curves, endurance). It runs a 5 s start countdown, then asserts the move command to the motor/steering logic. It ends the run on the finish sensor, a sustained line loss, a run timeout, or an operator stop press. All timing is derived from one clock through an internal 1 Hz tick.

## Interface
Parameters:
- SEC_DIV, 50_000_000: clock cycles per second; the bench overrides it to 10.
- START_SEC, 5: countdown length in seconds; range 1..7.
- RUN_MAX_SEC, 120: run timeout in seconds; range 1..255.
- LOST_CYC, 1_000_000: number of consecutive cycles of line_lost that raise a fault.

Ports:
- clk, in, 1: the single clock. One clock; reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high reset.
- buton, in, 1: raw asynchronous push-button, active-high.
- finish, in, 1: finish-line sensor, synchronous, level.
- line_lost, in, 1: no line under any sensor, synchronous, level.
- circuit, out, 2: selected trial. 0 = none, 1 = line, 2 = curves, 3 = endurance.
- led1/led2/led3, out, 1 each: one-hot decode of circuit. All three are 0 when circuit = 0.
- countdown, out, 3: remaining start seconds. It is 0 outside the COUNTDOWN state.
- move_en, out, 1: motor enable. High only in the RUN state.
- run_sec, out, 8: elapsed run seconds. It saturates at 255.
- done, out, 1: run completed normally.
- fault, out, 1: run aborted by line loss or timeout.

## Operation
- Button path:
  - 2-FF synchronizer, then rising-edge detect.
  - A press is accepted only when the lockout counter is 0.
  - An accepted press loads the lockout counter with SEC_DIV cycles (1 s). Edges during lockout are discarded.
- 1 Hz tick: the prescaler counts from 0 to SEC_DIV-1 and emits a one-cycle tick on the terminal count. It is cleared on entry to COUNTDOWN and on entry to RUN.
- States: IDLE, COUNTDOWN, RUN, DONE, FAULT.
- IDLE:
  - Outputs: circuit=0, move_en=0, done=0, fault=0, run_sec=0.
  - Accepted press: circuit=1, countdown=START_SEC, go to COUNTDOWN.
- COUNTDOWN:
  - Each tick decrements countdown.
  - A tick with countdown=1 goes to RUN: countdown=0, run_sec=0, move_en=1.
  - Accepted press: circuit advances by 1, and 3 wraps to 0.
    - If the new circuit is 0: go to IDLE.
    - Otherwise: countdown reloads to START_SEC and the prescaler clears.
- RUN:
  - Each tick increments run_sec, saturating at 255.
  - The lost counter counts consecutive cycles with line_lost=1 and clears on any cycle with line_lost=0.
  - Exit priority, highest first:
    - (1) accepted press: go to IDLE, circuit=0 (operator stop).
    - (2) finish=1: go to DONE.
    - (3) lost counter reaches LOST_CYC: go to FAULT.
    - (4) a tick that makes run_sec equal RUN_MAX_SEC: go to FAULT.
- DONE and FAULT:
  - move_en=0. run_sec and circuit hold.
  - done=1 in DONE; fault=1 in FAULT.
  - Accepted press: go to IDLE, circuit=0.
- circuit and the LEDs are registered and change on the same edge.
- reset (synchronous) applies in any state, including mid-run:
  - State goes to IDLE, and every output returns to 0.
  - Synchronizer flops, lockout, prescaler and lost counter clear.
  - move_en falls on the same edge that samples reset.

## Timing
- If buton is sampled high first at edge k, the accepted-press effects appear on the outputs after edge k+2.
- COUNTDOWN entered at edge e:
  - countdown changes at e+SEC_DIV, e+2·SEC_DIV, and so on.
  - move_en rises at edge e+START_SEC·SEC_DIV.
- finish sampled high at edge f: move_en=0 and done=1 after edge f+1, one cycle of latency.
- Fault on line loss: fault rises on the edge on which the lost counter reaches LOST_CYC. That edge is the LOST_CYC-th consecutive high-sample edge.
- Lockout spans SEC_DIV cycles, starting from the accepted edge. A second edge SEC_DIV or more cycles after the first is accepted.
- Simultaneous events follow the RUN priority list. A tick and a press in the same COUNTDOWN cycle: the press wins, and countdown reloads rather than decrementing.

## Test plan
All scenarios use SEC_DIV=10, START_SEC=5, RUN_MAX_SEC=8, LOST_CYC=4.
- Single press from IDLE → circuit=1 and led1=1 two edges after sync. countdown steps 5,4,3,2,1 every 10 cycles. move_en=1 exactly 50 cycles after COUNTDOWN entry.
- Button bounce of 3 edges within 6 cycles → exactly one accepted press, so circuit=1. A press 12 cycles later → circuit=2, led2=1, countdown reloaded to 5.
- Four presses spaced 15 cycles apart → circuit goes 1,2,3,0. The final press returns to IDLE with all LEDs off and move_en never asserted.
- In RUN, finish pulsed after 25 cycles → done=1 and move_en=0 one cycle later, run_sec=2 holds. A press then → IDLE, circuit=0.
- In RUN:
  - line_lost high for 3 cycles, low 1, high 4 → fault only on the 4th consecutive high sample.
  - With no finish, timeout → fault=1 when run_sec reaches 8.
- Mid-RUN reset pulse, and finish with press in the same cycle → reset: IDLE and all outputs 0 on the next edge. Finish with press: IDLE, not DONE.

Source files
------------

// File: rtl/proba_sequencer.sv
// Run sequencer for the line-follower car: debounced track select, start countdown,
// run supervision (finish, line loss, timeout, operator stop) on a 1 Hz internal tick.
module proba_sequencer #(
  parameter int unsigned SEC_DIV     = 50_000_000,
  parameter int unsigned START_SEC   = 5,
  parameter int unsigned RUN_MAX_SEC = 120,
  parameter int unsigned LOST_CYC    = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buton,
  input  logic       finish,
  input  logic       line_lost,
  output logic [1:0] circuit,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [2:0] countdown,
  output logic       move_en,
  output logic [7:0] run_sec,
  output logic       done,
  output logic       fault
);

  localparam int unsigned PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int unsigned LW = $clog2(LOST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state;
  logic [2:0]    btn_sync;
  logic [PW-1:0] lockout;
  logic [PW-1:0] presc;
  logic [LW-1:0] lost_cnt;
  logic          finish_q;

  logic          press;
  logic          accept;
  logic          tick;
  logic          lost_hit;
  logic          presc_clr;
  logic [1:0]    circuit_inc;
  logic [7:0]    run_sec_inc;

  function automatic logic [2:0] led_decode(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // btn_sync[1:0] is the synchronizer, btn_sync[2] the previous value for edge detect
  assign press       = btn_sync[1] & ~btn_sync[2];
  assign accept      = press && (lockout == '0);
  assign tick        = (presc == PW'(SEC_DIV - 1));
  assign circuit_inc = circuit + 2'd1;
  assign run_sec_inc = (run_sec == 8'd255) ? run_sec : run_sec + 8'd1;
  assign lost_hit    = line_lost && (lost_cnt == LW'(LOST_CYC - 1));
  assign presc_clr   = ((state == S_IDLE) && accept) ||
                       ((state == S_COUNTDOWN) && (accept || (tick && countdown == 3'd1)));

  always_ff @(posedge clk) begin
    if (reset) btn_sync <= '0;
    else       btn_sync <= {btn_sync[1:0], buton};
  end

  // Lockout loaded so that an edge SEC_DIV cycles after the accepted one is taken again
  always_ff @(posedge clk) begin
    if (reset)               lockout <= '0;
    else if (accept)         lockout <= PW'(SEC_DIV - 1);
    else if (lockout != '0)  lockout <= lockout - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)                  presc <= '0;
    else if (presc_clr || tick) presc <= '0;
    else                        presc <= presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)                               lost_cnt <= '0;
    else if (state == S_RUN && line_lost)    lost_cnt <= lost_cnt + LW'(1);
    else                                     lost_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) finish_q <= 1'b0;
    else       finish_q <= finish;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      circuit            <= 2'd0;
      {led1, led2, led3} <= 3'b000;
      countdown          <= 3'd0;
      move_en            <= 1'b0;
      run_sec            <= 8'd0;
      done               <= 1'b0;
      fault              <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state              <= S_COUNTDOWN;
            circuit            <= 2'd1;
            {led1, led2, led3} <= led_decode(2'd1);
            countdown          <= 3'(START_SEC);
          end
        end
        S_COUNTDOWN: begin
          if (accept) begin
            circuit            <= circuit_inc;
            {led1, led2, led3} <= led_decode(circuit_inc);
            if (circuit_inc == 2'd0) begin
              state     <= S_IDLE;
              countdown <= 3'd0;
            end else begin
              countdown <= 3'(START_SEC);
            end
          end else if (tick) begin
            if (countdown == 3'd1) begin
              state     <= S_RUN;
              countdown <= 3'd0;
              run_sec   <= 8'd0;
              move_en   <= 1'b1;
            end else begin
              countdown <= countdown - 3'd1;
            end
          end
        end
        S_RUN: begin
          // Operator stop outranks finish, which outranks line loss, then timeout
          if (accept) begin
            state              <= S_IDLE;
            circuit            <= 2'd0;
            {led1, led2, led3} <= 3'b000;
            move_en            <= 1'b0;
            run_sec            <= 8'd0;
          end else begin
            if (tick) run_sec <= run_sec_inc;
            if (finish_q) begin
              state   <= S_DONE;
              move_en <= 1'b0;
              done    <= 1'b1;
            end else if (lost_hit || (tick && run_sec_inc == 8'(RUN_MAX_SEC))) begin
              state   <= S_FAULT;
              move_en <= 1'b0;
              fault   <= 1'b1;
            end
          end
        end
        S_DONE, S_FAULT: begin
          if (accept) begin
            state              <= S_IDLE;
            circuit            <= 2'd0;
            {led1, led2, led3} <= 3'b000;
            run_sec            <= 8'd0;
            done               <= 1'b0;
            fault              <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proba_sequencer.sv
// Bench for proba_sequencer: directed scenarios plus random traffic, each checked
// against a timestamp-based reference model of the run sequencer.
module tb_proba_sequencer;

  localparam int unsigned SEC   = 10;
  localparam int unsigned START = 5;
  localparam int unsigned RMAX  = 8;
  localparam int unsigned LOST  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_CD    = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;
  localparam int P_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset, buton, finish, line_lost;
  logic [1:0] circuit;
  logic       led1, led2, led3;
  logic [2:0] countdown;
  logic       move_en;
  logic [7:0] run_sec;
  logic       done, fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  proba_sequencer #(
    .SEC_DIV    (SEC),
    .START_SEC  (START),
    .RUN_MAX_SEC(RMAX),
    .LOST_CYC   (LOST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .buton    (buton),
    .finish   (finish),
    .line_lost(line_lost),
    .circuit  (circuit),
    .led1     (led1),
    .led2     (led2),
    .led3     (led3),
    .countdown(countdown),
    .move_en  (move_en),
    .run_sec  (run_sec),
    .done     (done),
    .fault    (fault)
  );

  logic [17:0] obs_vec;
  assign obs_vec = {circuit, led1, led2, led3, countdown, move_en, run_sec, done, fault};

  // Reference model: button history, accept timestamps, phase entry timestamps
  int unsigned cyc_n = 0;
  bit          h1, h2, h3, has_acc, fin_d;
  int unsigned last_acc, cd_start, run_start;
  int          m_phase = P_IDLE;
  int          m_circuit = 0;
  int          m_rs = 0;
  int          m_lost = 0;

  function automatic logic [17:0] exp_vec();
    logic [1:0] c;
    logic [2:0] cd;
    c  = 2'(m_circuit);
    cd = (m_phase == P_CD) ? 3'(START - (cyc_n - cd_start) / SEC) : 3'd0;
    return {c, c == 2'd1, c == 2'd2, c == 2'd3, cd, m_phase == P_RUN, 8'(m_rs),
            m_phase == P_DONE, m_phase == P_FAULT};
  endfunction

  task automatic model_step();
    bit press, acc, fin;
    int unsigned secs;
    cyc_n++;
    if (reset) begin
      h1 = 0; h2 = 0; h3 = 0; has_acc = 0; fin_d = 0;
      m_phase = P_IDLE; m_circuit = 0; m_rs = 0; m_lost = 0;
      return;
    end
    press = h2 && !h3;
    h3 = h2; h2 = h1; h1 = buton;
    acc = press && (!has_acc || (cyc_n - last_acc >= SEC));
    if (acc) begin
      has_acc  = 1;
      last_acc = cyc_n;
    end
    fin   = fin_d;
    fin_d = finish;
    case (m_phase)
      P_IDLE: begin
        m_rs = 0;
        if (acc) begin
          m_circuit = 1; cd_start = cyc_n; m_phase = P_CD;
        end
      end
      P_CD: begin
        if (acc) begin
          m_circuit = (m_circuit + 1) % 4;
          if (m_circuit == 0) m_phase = P_IDLE;
          else                cd_start = cyc_n;
        end else if (cyc_n - cd_start == START * SEC) begin
          m_phase = P_RUN; run_start = cyc_n; m_rs = 0; m_lost = 0;
        end
      end
      P_RUN: begin
        if (acc) begin
          m_phase = P_IDLE; m_circuit = 0; m_rs = 0;
        end else begin
          secs   = (cyc_n - run_start) / SEC;
          m_rs   = (secs > 255) ? 255 : int'(secs);
          m_lost = line_lost ? m_lost + 1 : 0;
          if (fin)                      m_phase = P_DONE;
          else if (m_lost == int'(LOST)) m_phase = P_FAULT;
          else if (m_rs == int'(RMAX))   m_phase = P_FAULT;
        end
      end
      default: begin
        if (acc) begin
          m_phase = P_IDLE; m_circuit = 0; m_rs = 0;
        end
      end
    endcase
  endtask

  // One clock: apply inputs at the falling edge, step the model, return at the next falling edge
  task automatic cyc(input logic b, input logic f, input logic l);
    buton = b; finish = f; line_lost = l;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic go_run();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (52) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checks++;
    if (obs_vec !== 18'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs_vec, 18'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== 18'd0 || obs_vec !== exp_vec()) begin
        failures++; $display("FAIL reset_idle got=%h exp=%h", obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_single_press();
    int w, j;
    do_reset();
    repeat ($urandom_range(0, 7)) cyc(1'b0, 1'b0, 1'b0);
    w = $urandom_range(1, 4);
    for (int i = 0; i <= 52; i++) begin
      cyc(i < w, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL single_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (circuit !== 2'd0) begin
          failures++; $display("FAIL single_early circuit=%0d exp=0", circuit);
        end
      end
      if (i >= 2) begin
        j = i - 2;
        checks++;
        if (countdown !== ((j < 50) ? 3'(5 - j / 10) : 3'd0) || move_en !== (j == 50) ||
            circuit !== 2'd1 || led1 !== 1'b1) begin
          failures++;
          $display("FAIL single_countdown j=%0d cd=%0d mv=%b c=%0d led1=%b exp cd=%0d mv=%b c=1",
                   j, countdown, move_en, circuit, led1, (j < 50) ? 5 - j / 10 : 0, j == 50);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic b;
    do_reset();
    repeat ($urandom_range(0, 5)) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 16; i++) begin
      b = (i < 6) ? (i % 2 == 0) : (i == 12);
      cyc(b, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL bounce_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (i >= 2 && i <= 13) begin
        checks++;
        if (circuit !== 2'd1) begin
          failures++; $display("FAIL bounce_single i=%0d circuit=%0d exp=1", i, circuit);
        end
      end
      if (i == 13) begin
        checks++;
        if (countdown !== 3'd4) begin
          failures++; $display("FAIL bounce_tick countdown=%0d exp=4", countdown);
        end
      end
      if (i == 14) begin
        checks++;
        if (circuit !== 2'd2 || led2 !== 1'b1 || led1 !== 1'b0 || countdown !== 3'd5) begin
          failures++;
          $display("FAIL bounce_second c=%0d led2=%b led1=%b cd=%0d exp c=2 led2=1 led1=0 cd=5",
                   circuit, led2, led1, countdown);
        end
      end
    end
  endtask

  task automatic test_cycle_circuits();
    int at[4];
    logic b;
    do_reset();
    at[0] = 0;
    for (int j = 1; j < 4; j++) at[j] = at[j-1] + 15 + int'($urandom_range(0, 3));
    for (int i = 0; i <= at[3] + 4; i++) begin
      b = 1'b0;
      for (int j = 0; j < 4; j++) if (i == at[j]) b = 1'b1;
      cyc(b, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec() || move_en !== 1'b0) begin
        failures++; $display("FAIL cycle_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      for (int j = 0; j < 4; j++) begin
        if (i == at[j] + 2) begin
          checks++;
          if (circuit !== 2'((j + 1) % 4)) begin
            failures++; $display("FAIL cycle_step j=%0d circuit=%0d exp=%0d", j, circuit, (j + 1) % 4);
          end
        end
      end
    end
    checks++;
    if (circuit !== 2'd0 || {led1, led2, led3} !== 3'b000 || countdown !== 3'd0) begin
      failures++;
      $display("FAIL cycle_final c=%0d leds=%b cd=%0d exp 0", circuit, {led1, led2, led3}, countdown);
    end
  endtask

  task automatic test_finish();
    go_run();
    checks++;
    if (move_en !== 1'b1 || run_sec !== 8'd0 || countdown !== 3'd0) begin
      failures++; $display("FAIL finish_enter mv=%b rs=%0d cd=%0d exp 1,0,0", move_en, run_sec, countdown);
    end
    for (int i = 1; i <= 40; i++) begin
      cyc(i == 32, i == 26, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL finish_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (i == 26) begin
        checks++;
        if (done !== 1'b0 || move_en !== 1'b1) begin
          failures++; $display("FAIL finish_latency done=%b mv=%b exp 0,1", done, move_en);
        end
      end
      if (i >= 27 && i <= 33) begin
        checks++;
        if (done !== 1'b1 || move_en !== 1'b0 || run_sec !== 8'd2 || circuit !== 2'd1) begin
          failures++;
          $display("FAIL finish_done i=%0d done=%b mv=%b rs=%0d c=%0d exp 1,0,2,1", i, done, move_en, run_sec, circuit);
        end
      end
      if (i >= 34) begin
        checks++;
        if (done !== 1'b0 || circuit !== 2'd0 || run_sec !== 8'd0) begin
          failures++; $display("FAIL finish_exit i=%0d done=%b c=%0d rs=%0d exp 0,0,0", i, done, circuit, run_sec);
        end
      end
    end
  endtask

  task automatic test_line_lost();
    logic [7:0] pat;
    logic l;
    int pre, k;
    pat = 8'b1111_0111;
    go_run();
    pre = $urandom_range(0, 3);
    for (int i = 0; i <= pre + 9; i++) begin
      k = i - pre;
      l = (k >= 0 && k < 8) ? pat[3'(k)] : 1'b0;
      cyc(1'b0, 1'b0, l);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL lost_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      checks++;
      if (fault !== (k >= 7) || move_en !== (k < 7)) begin
        failures++; $display("FAIL lost_fault k=%0d fault=%b mv=%b exp %b,%b", k, fault, move_en, k >= 7, k < 7);
      end
    end
  endtask

  task automatic test_timeout();
    logic l;
    go_run();
    for (int i = 1; i <= 85; i++) begin
      l = (i % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      cyc(1'b0, 1'b0, l);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL timeout_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      checks++;
      if (fault !== (i >= 80) || run_sec !== ((i < 80) ? 8'(i / 10) : 8'd8)) begin
        failures++;
        $display("FAIL timeout_run i=%0d fault=%b rs=%0d exp %b,%0d", i, fault, run_sec, i >= 80, (i < 80) ? i / 10 : 8);
      end
    end
  endtask

  task automatic test_mid_reset_and_collision();
    go_run();
    repeat ($urandom_range(5, 30)) cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec !== 18'd0 || obs_vec !== exp_vec()) begin
      failures++; $display("FAIL midrun_reset got=%h exp=%h", obs_vec, 18'd0);
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec !== 18'd0) begin
      failures++; $display("FAIL midrun_after got=%h exp=%h", obs_vec, 18'd0);
    end
    go_run();
    repeat ($urandom_range(3, 20)) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (move_en !== 1'b1) begin
      failures++; $display("FAIL collide_pre mv=%b exp=1", move_en);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (circuit !== 2'd0 || done !== 1'b0 || move_en !== 1'b0 || obs_vec !== exp_vec()) begin
      failures++; $display("FAIL collide_idle got=%h exp=%h", obs_vec, exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0 || obs_vec !== 18'd0) begin
      failures++; $display("FAIL collide_hold got=%h exp=%h", obs_vec, 18'd0);
    end
  endtask

  task automatic test_random();
    int hold;
    logic b;
    hold = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (hold > 0) begin
        hold--; b = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        hold = $urandom_range(0, 2); b = 1'b1;
      end else begin
        b = 1'b0;
      end
      reset = ($urandom_range(0, 399) == 0);
      cyc(b, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++; $display("FAIL random_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; buton = 1'b0; finish = 1'b0; line_lost = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_bounce();
    test_cycle_circuits();
    test_finish();
    test_line_lost();
    test_timeout();
    test_mid_reset_and_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
